// File: rtl/scan_code_sequencer.sv
// Set-2 scan-code sequencer for keys A-D: prefix FSM, held-key tracking,
// FWFT event FIFO with valid/ready handshake and LED mirror.
module scan_code_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_code_ready,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_key,
  output logic       evt_release,
  output logic [3:0] keys_held,
  output logic       overflow,
  output logic       LD0,
  output logic       LD1,
  output logic       LD2,
  output logic       LD3
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;

  logic       code_hit;
  logic [1:0] code_key;
  logic       gen_v;
  logic       gen_rel;

  logic       stg_v;
  logic [1:0] stg_key;
  logic       stg_rel;

  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          full;
  logic          pop;
  logic          do_push;
  logic [CW-1:0] count_ap;
  logic [CW-1:0] count_n;
  logic [AW-1:0] rd_n;

  always_comb begin
    code_hit = 1'b1;
    code_key = 2'd0;
    unique case (1'b1)
      (scan_code == 8'h1C): code_key = 2'd0;
      (scan_code == 8'h32): code_key = 2'd1;
      (scan_code == 8'h21): code_key = 2'd2;
      (scan_code == 8'h23): code_key = 2'd3;
      default:              code_hit = 1'b0;
    endcase
  end

  // Typematic repeats and releases of unheld keys produce no event.
  always_comb begin
    gen_v   = 1'b0;
    gen_rel = 1'b0;
    if (scan_code_ready && code_hit) begin
      if (state == IDLE && !keys_held[code_key]) begin
        gen_v = 1'b1;
      end else if (state == BRK && keys_held[code_key]) begin
        gen_v   = 1'b1;
        gen_rel = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      keys_held <= '0;
    end else if (scan_code_ready) begin
      tmo_cnt <= '0;
      case (state)
        IDLE: begin
          if (scan_code == BRK_CODE) begin
            state <= BRK;
          end else if (scan_code == EXT_CODE) begin
            state <= EXT;
          end else if (gen_v) begin
            keys_held[code_key] <= 1'b1;
          end
        end
        BRK: begin
          if (gen_v) begin
            keys_held[code_key] <= 1'b0;
          end
          state <= IDLE;
        end
        EXT: begin
          state <= (scan_code == BRK_CODE) ? EXT_BRK : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end else if (state != IDLE) begin
      if (tmo_cnt == TW'(PREFIX_TIMEOUT)) begin
        state   <= IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // One-cycle event stage keeps the FIFO push aligned with the LED register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_v   <= 1'b0;
      stg_key <= '0;
      stg_rel <= 1'b0;
    end else begin
      stg_v   <= gen_v;
      stg_key <= code_key;
      stg_rel <= gen_rel;
    end
  end

  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = evt_valid & evt_ready;
  assign do_push  = stg_v & (~full | pop);
  assign count_ap = count - CW'(pop);
  assign count_n  = count_ap + CW'(do_push);
  assign rd_n     = rd_ptr + AW'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      evt_valid   <= 1'b0;
      evt_key     <= '0;
      evt_release <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {stg_key, stg_rel};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr    <= rd_n;
      count     <= count_n;
      evt_valid <= (count_n != '0);
      // Registered head: bypass the write when pushing into an empty queue.
      if (count_n != '0) begin
        if (count_ap == '0) begin
          {evt_key, evt_release} <= {stg_key, stg_rel};
        end else begin
          {evt_key, evt_release} <= mem[rd_n];
        end
      end
      if (stg_v && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LD0 <= 1'b0;
      LD1 <= 1'b0;
      LD2 <= 1'b0;
      LD3 <= 1'b0;
    end else begin
      LD0 <= keys_held[0];
      LD1 <= keys_held[1];
      LD2 <= keys_held[2];
      LD3 <= keys_held[3];
    end
  end

endmodule

// File: tb/tb_scan_code_sequencer.sv
// Bench for scan_code_sequencer: directed test-plan steps plus random
// byte streams against a queue-based reference of the key-event rules.
module tb_scan_code_sequencer;

  localparam int D = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_code_ready = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic       evt_release;
  logic [3:0] keys_held;
  logic       overflow;
  logic       LD0, LD1, LD2, LD3;

  scan_code_sequencer #(
    .FIFO_DEPTH(D),
    .PREFIX_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .scan_code(scan_code),
    .scan_code_ready(scan_code_ready),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key(evt_key),
    .evt_release(evt_release),
    .keys_held(keys_held),
    .overflow(overflow),
    .LD0(LD0),
    .LD1(LD1),
    .LD2(LD2),
    .LD3(LD3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] key;
    logic       rel;
  } ev_t;

  int errors = 0;
  int checks = 0;

  ev_t         mq[$];
  logic [7:0]  pfx[$];
  logic [3:0]  m_held;
  logic [3:0]  m_ld;
  logic        m_ovf;
  logic        stg_v;
  ev_t         stg;
  int          edge_n = 0;
  int          last_e = 0;
  int          dut_pops = 0;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int key_of(input logic [7:0] b);
    case (b)
      8'h1C: return 0;
      8'h32: return 1;
      8'h21: return 2;
      8'h23: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    pfx.delete();
    m_held = '0;
    m_ld   = '0;
    m_ovf  = 1'b0;
    stg_v  = 1'b0;
    stg    = '0;
  endtask

  // A pending prefix survives a gap of up to T+1 edges between strobes.
  task automatic decode(input logic [7:0] b);
    int k;
    k = key_of(b);
    if (pfx.size() != 0 && edge_n - last_e > T + 1) pfx.delete();
    last_e = edge_n;
    if (pfx.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) begin
        pfx.push_back(b);
      end else if (k >= 0 && !m_held[k]) begin
        m_held[k] = 1'b1;
        stg_v = 1'b1;
        stg = '{key: 2'(k), rel: 1'b0};
      end
    end else if (pfx.size() == 1 && pfx[0] == 8'hF0) begin
      pfx.delete();
      if (k >= 0 && m_held[k]) begin
        m_held[k] = 1'b0;
        stg_v = 1'b1;
        stg = '{key: 2'(k), rel: 1'b1};
      end
    end else if (pfx.size() == 1) begin
      if (b == 8'hF0) pfx.push_back(b);
      else pfx.delete();
    end else begin
      pfx.delete();
    end
  endtask

  task automatic tick();
    ev_t h;
    @(negedge clk);
    if (reset) begin
      chk("rst_valid", 8'(evt_valid), 8'd0);
      chk("rst_key", 8'(evt_key), 8'd0);
      chk("rst_release", 8'(evt_release), 8'd0);
      chk("rst_held", 8'(keys_held), 8'd0);
      chk("rst_ld", 8'({LD3, LD2, LD1, LD0}), 8'd0);
      chk("rst_ovf", 8'(overflow), 8'd0);
      model_reset();
    end else begin
      chk("evt_valid", 8'(evt_valid), 8'(mq.size() != 0));
      if (mq.size() != 0) begin
        h = mq[0];
        chk("evt_key", 8'(evt_key), 8'(h.key));
        chk("evt_release", 8'(evt_release), 8'(h.rel));
      end
      chk("keys_held", 8'(keys_held), 8'(m_held));
      chk("ld", 8'({LD3, LD2, LD1, LD0}), 8'(m_ld));
      chk("overflow", 8'(overflow), 8'(m_ovf));
      if (evt_valid && evt_ready) dut_pops++;
      if (mq.size() != 0 && evt_ready) h = mq.pop_front();
      if (stg_v) begin
        if (mq.size() < D) mq.push_back(stg);
        else m_ovf = 1'b1;
      end
      stg_v = 1'b0;
      m_ld = m_held;
      if (scan_code_ready) decode(scan_code);
    end
    edge_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit s, input logic [7:0] c, input bit r);
    scan_code_ready = s;
    scan_code = c;
    evt_ready = r;
    tick();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] pick [8];
    int p0;
    int r;
    pick = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'hF0, 8'hF0, 8'hE0, 8'h12};
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // A press, popped on the following cycle
    step(1'b1, 8'h1C, 1'b1);
    chk("t1_held", 8'(keys_held), 8'h01);
    chk("t1_valid_lat", 8'(evt_valid), 8'd0);
    idle(1, 1'b1);
    chk("t1_valid", 8'(evt_valid), 8'd1);
    chk("t1_key", 8'(evt_key), 8'd0);
    chk("t1_rel", 8'(evt_release), 8'd0);
    chk("t1_ld0", 8'(LD0), 8'd1);
    idle(1, 1'b1);
    chk("t1_drained", 8'(evt_valid), 8'd0);

    // B typematic repeat then release
    p0 = dut_pops;
    step(1'b1, 8'h32, 1'b1);
    step(1'b1, 8'h32, 1'b1);
    step(1'b1, 8'h32, 1'b1);
    step(1'b1, 8'hF0, 1'b1);
    step(1'b1, 8'h32, 1'b1);
    idle(4, 1'b1);
    chk("t2_events", 8'(dut_pops - p0), 8'd2);
    chk("t2_held", 8'(keys_held), 8'h01);

    // Extended sequences are ignored; prefix timeout
    p0 = dut_pops;
    step(1'b1, 8'hE0, 1'b1);
    step(1'b1, 8'h1C, 1'b1);
    step(1'b1, 8'hE0, 1'b1);
    step(1'b1, 8'hF0, 1'b1);
    step(1'b1, 8'h1C, 1'b1);
    idle(3, 1'b1);
    chk("t3_events", 8'(dut_pops - p0), 8'd0);
    chk("t3_held", 8'(keys_held), 8'h01);
    step(1'b1, 8'hF0, 1'b1);
    idle(T + 2, 1'b1);
    step(1'b1, 8'h21, 1'b1);
    idle(3, 1'b1);
    chk("t3_timeout_press", 8'(keys_held), 8'h05);

    // Overflow with consumer stalled
    do_reset();
    step(1'b1, 8'h1C, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h23, 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    idle(3, 1'b0);
    chk("t4_ovf", 8'(overflow), 8'd1);
    chk("t4_held", 8'(keys_held), 8'he);
    p0 = dut_pops;
    idle(8, 1'b1);
    chk("t4_drain", 8'(dut_pops - p0), 8'd4);

    // Push and pop on a full FIFO in the same cycle
    do_reset();
    p0 = dut_pops;
    step(1'b1, 8'h1C, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h23, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    idle(2, 1'b0);
    chk("t5_no_ovf", 8'(overflow), 8'd0);
    idle(8, 1'b1);
    chk("t5_total", 8'(dut_pops - p0), 8'd5);

    // Asynchronous reset inside a break prefix
    do_reset();
    step(1'b1, 8'h23, 1'b1);
    idle(3, 1'b1);
    chk("t6_held_d", 8'(keys_held), 8'h08);
    step(1'b1, 8'hF0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_held", 8'(keys_held), 8'd0);
    chk("t6_async_ld", 8'({LD3, LD2, LD1, LD0}), 8'd0);
    chk("t6_async_valid", 8'(evt_valid), 8'd0);
    chk("t6_async_ovf", 8'(overflow), 8'd0);
    scan_code_ready = 1'b0;
    idle(2, 1'b1);
    reset = 1'b0;
    step(1'b1, 8'h23, 1'b1);
    idle(3, 1'b1);
    chk("t6_d_press", 8'(keys_held), 8'h08);

    // Random byte streams, gaps and back-pressure
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 19);
      if (r < 10) begin
        step(1'b1, pick[$urandom_range(0, 7)], $urandom_range(0, 3) != 0);
      end else if (r == 19) begin
        idle(T - 1 + $urandom_range(0, 4), $urandom_range(0, 1) != 0);
      end else begin
        step(1'b0, 8'h00, $urandom_range(0, 3) != 0);
      end
    end
    idle(10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
